dyt_regfile_sb: RTL and testbench
=================================

Name: dyt_regfile_sb

Overview:
Parametrised successor to the base integer register file, sized for RV32I (32 regs) or RV32E (16 regs).
- Ports: two asynchronous read ports, one synchronous write port.
- Adds a per-register scoreboard: busy bits reserved at issue and cleared at writeback, plus a pipeline flush.
- Sits between decode/issue (read, reserve) and writeback (write, release) in the dyt core.

Parameters:
XLEN, 32, data width of each register.
ADDR_WIDTH, 5, register address width; NUM_WORDS = 2**ADDR_WIDTH (5 -> 32 regs RV32I, 4 -> 16 regs RV32E).
ZERO_REG, 1, 1 makes x0 hardwired zero, never written, never busy; 0 makes x0 an ordinary register.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous active-low reset.
w_en  input  1  writeback enable.
w_addr  input  ADDR_WIDTH  writeback register address.
w_data  input  XLEN  writeback data.
r_a_addr  input  ADDR_WIDTH  read port A address.
r_a_data  output  XLEN  read port A data.
r_a_busy  output  1  register at r_a_addr has a pending write.
r_b_addr  input  ADDR_WIDTH  read port B address.
r_b_data  output  XLEN  read port B data.
r_b_busy  output  1  register at r_b_addr has a pending write.
rsv_en  input  1  issue request to reserve a destination register.
rsv_addr  input  ADDR_WIDTH  destination register to reserve.
rsv_stall  output  1  combinational; reservation refused because rsv_addr is already busy.
flush  input  1  synchronous clear of all busy bits (pipeline flush).
busy_cnt  output  ADDR_WIDTH+1  registered count of busy registers.

Behaviour:
- Reset (rst low, asynchronous): all registers 0, all busy bits 0, busy_cnt 0.
  - Outputs during reset: r_*_data 0, r_*_busy 0, rsv_stall 0.
- Reads: combinational, zero latency.
  - r_x_data = reg[r_x_addr]; r_x_busy = busy[r_x_addr].
  - With ZERO_REG=1, address 0 returns data 0 and busy 0.
- Write: on a clk edge with w_en=1, reg[w_addr] <= w_data and busy[w_addr] <= 0.
  - Writes to x0 are ignored when ZERO_REG=1.
  - Writing a non-busy register is legal; it updates data and leaves busy at 0.
- Reserve: rsv_stall = rsv_en & busy[rsv_addr] & ~(w_en & w_addr==rsv_addr).
  - On an edge with rsv_en=1 and rsv_stall=0: busy[rsv_addr] <= 1.
  - Reserving x0 when ZERO_REG=1: accepted, no effect, no stall.
- Simultaneous write and reserve on the same address: the write completes the old instruction and the reserve claims the new one.
  - Net result: data updated, busy=1, rsv_stall=0.
- Flush: on an edge with flush=1, all busy bits <= 0.
  - A write in the same cycle still updates data.
  - A reserve in the same cycle is dropped; flush has priority over reserve.
  - rsv_stall still evaluates combinationally; issue logic ignores it during flush.
- busy_cnt: registered popcount of busy bits after the update, so it is valid one cycle after the change. Range 0..NUM_WORDS.
- Same-cycle read of an address being written returns the old data unless the bypass option below is enabled.
- Reset asserted mid-operation: all state clears immediately; pending reservations are lost.

Optional Feature:
DYT_RF_BYPASS_EN
- Defined: write-through forwarding. If w_en=1 and w_addr==r_x_addr (and not x0 when ZERO_REG=1), then r_x_data=w_data and r_x_busy=0 in the same cycle.
- Undefined: reads return stored state only; the new value is visible the cycle after the write.

Decomposition:
- Package dyt_rf_pkg: XLEN default, ADDR_WIDTH default, NUM_WORDS function/constant, reg_addr_t and xlen_t typedefs, ZERO_ADDR constant.
- One sub-module, dyt_rf_scoreboard: owns the busy vector, reserve/release/flush priority, rsv_stall and the busy_cnt popcount.
- The data array, write decode and read muxes stay in the top module.

Test Plan:
1. Reset, then write 0xDEADBEEF to x5; read A=x5 next cycle -> r_a_data=0xDEADBEEF, busy 0. Write 0x1234 to x0 -> reads 0.
2. Reserve x7; next cycle r_b_addr=7 -> r_b_busy=1, busy_cnt=1. Reserve x7 again -> rsv_stall=1, busy_cnt stays 1.
3. Same cycle: w_en to x7 with 0xA5A5A5A5 and rsv_en to x7 -> rsv_stall=0; next cycle data=0xA5A5A5A5, busy=1.
4. Reserve x1, x2, x3, then flush together with rsv_en x4 -> all busy 0, x4 not busy, busy_cnt=0 two cycles later.
5. ADDR_WIDTH=4: reserve all x1..x15 -> busy_cnt=15; write x15 -> busy_cnt=14.
6. DYT_RF_BYPASS_EN defined: w_en x9=0x55, r_a_addr=9 in the same cycle -> r_a_data=0x55 combinationally. Undefined: old value, new value next cycle. Assert rst mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/dyt_rf_pkg.sv
// rtl/dyt_rf_pkg.sv - shared types and constants for the dyt scoreboarded register file
package dyt_rf_pkg;

  localparam int unsigned DEF_XLEN       = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned ZERO_ADDR      = 0;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_XLEN-1:0]       xlen_t;

  // Number of architectural registers for a given address width.
  function automatic int unsigned num_words(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/dyt_regfile_sb_if.sv
// rtl/dyt_regfile_sb_if.sv - issue/writeback bus of the scoreboarded register file
interface dyt_regfile_sb_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 5
);

  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [XLEN-1:0]       w_data;
  logic [ADDR_WIDTH-1:0] r_a_addr;
  logic [XLEN-1:0]       r_a_data;
  logic                  r_a_busy;
  logic [ADDR_WIDTH-1:0] r_b_addr;
  logic [XLEN-1:0]       r_b_data;
  logic                  r_b_busy;
  logic                  rsv_en;
  logic [ADDR_WIDTH-1:0] rsv_addr;
  logic                  rsv_stall;
  logic                  flush;
  logic [ADDR_WIDTH:0]   busy_cnt;

  modport master (
    output w_en, w_addr, w_data, r_a_addr, r_b_addr, rsv_en, rsv_addr, flush,
    input  r_a_data, r_a_busy, r_b_data, r_b_busy, rsv_stall, busy_cnt
  );

  modport slave (
    input  w_en, w_addr, w_data, r_a_addr, r_b_addr, rsv_en, rsv_addr, flush,
    output r_a_data, r_a_busy, r_b_data, r_b_busy, rsv_stall, busy_cnt
  );

endinterface

// File: rtl/dyt_rf_scoreboard.sv
// rtl/dyt_rf_scoreboard.sv - per-register busy bits with reserve/release/flush and popcount
module dyt_rf_scoreboard
  import dyt_rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1,
  localparam int unsigned NUM_WORDS = num_words(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  input  logic                  flush,
  output logic                  rsv_stall,
  output logic [NUM_WORDS-1:0]  busy,
  output logic [ADDR_WIDTH:0]   busy_cnt
);

  logic [NUM_WORDS-1:0] busy_nxt;
  logic [ADDR_WIDTH:0]  cnt_nxt;
  logic                 rel_ok;
  logic                 rsv_ok;

  // Refuse a reservation on a busy register unless this cycle's writeback releases it.
  always_comb begin
    rsv_stall = rsv_en & busy[rsv_addr] & ~(w_en & (w_addr == rsv_addr));
  end

  // Release before reserve so a same-address write+reserve leaves the register busy; flush wins.
  always_comb begin
    rel_ok   = w_en & ~(ZERO_REG && (w_addr == ADDR_WIDTH'(ZERO_ADDR)));
    rsv_ok   = rsv_en & ~rsv_stall & ~(ZERO_REG && (rsv_addr == ADDR_WIDTH'(ZERO_ADDR)));
    busy_nxt = busy;
    if (rel_ok) busy_nxt[w_addr] = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    cnt_nxt = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[i]};
    end
  end

  // Busy vector and its population count advance together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/dyt_regfile_sb.sv
// rtl/dyt_regfile_sb.sv - 2R/1W register file with scoreboard; optional DYT_RF_BYPASS_EN write-through
module dyt_regfile_sb
  import dyt_rf_pkg::*;
#(
  parameter int unsigned XLEN       = DEF_XLEN,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1
) (
  input logic             clk,
  input logic             rst,
  dyt_regfile_sb_if.slave bus
);

  localparam int unsigned NUM_WORDS = num_words(ADDR_WIDTH);

  logic [XLEN-1:0]      mem [NUM_WORDS];
  logic [NUM_WORDS-1:0] busy;
  logic                 wr_ok;
  logic [XLEN-1:0]      a_data;
  logic [XLEN-1:0]      b_data;
  logic                 a_busy;
  logic                 b_busy;

  dyt_rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .w_en      (bus.w_en),
    .w_addr    (bus.w_addr),
    .rsv_en    (bus.rsv_en),
    .rsv_addr  (bus.rsv_addr),
    .flush     (bus.flush),
    .rsv_stall (bus.rsv_stall),
    .busy      (busy),
    .busy_cnt  (bus.busy_cnt)
  );

  // x0 is never written when it is hardwired to zero.
  always_comb begin
    wr_ok = bus.w_en & ~(ZERO_REG && (bus.w_addr == ADDR_WIDTH'(ZERO_ADDR)));
  end

  // Data array write; flush does not affect data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (wr_ok) begin
      mem[bus.w_addr] <= bus.w_data;
    end
  end

  // Asynchronous read ports, x0 forced to zero/not-busy, optional write-through.
  always_comb begin
    a_data = mem[bus.r_a_addr];
    a_busy = busy[bus.r_a_addr];
    b_data = mem[bus.r_b_addr];
    b_busy = busy[bus.r_b_addr];
    if (ZERO_REG && (bus.r_a_addr == ADDR_WIDTH'(ZERO_ADDR))) begin
      a_data = '0;
      a_busy = 1'b0;
    end
    if (ZERO_REG && (bus.r_b_addr == ADDR_WIDTH'(ZERO_ADDR))) begin
      b_data = '0;
      b_busy = 1'b0;
    end
`ifdef DYT_RF_BYPASS_EN
    if (wr_ok && (bus.w_addr == bus.r_a_addr)) begin
      a_data = bus.w_data;
      a_busy = 1'b0;
    end
    if (wr_ok && (bus.w_addr == bus.r_b_addr)) begin
      b_data = bus.w_data;
      b_busy = 1'b0;
    end
`else
    // Stored state only; a write becomes visible the cycle after.
`endif
    bus.r_a_data = a_data;
    bus.r_a_busy = a_busy;
    bus.r_b_data = b_data;
    bus.r_b_busy = b_busy;
  end

endmodule

// File: tb/tb_dyt_regfile_sb.sv
// tb/tb_dyt_regfile_sb.sv - directed bench for dyt_regfile_sb (32-reg and 16-reg instances)
module tb_dyt_regfile_sb;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  bit   byp;

  dyt_regfile_sb_if #(.XLEN(32), .ADDR_WIDTH(5)) bus_a ();
  dyt_regfile_sb_if #(.XLEN(32), .ADDR_WIDTH(4)) bus_s ();

  dyt_regfile_sb #(.XLEN(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  dyt_regfile_sb #(.XLEN(32), .ADDR_WIDTH(4), .ZERO_REG(1'b1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_a.w_en = 0; bus_a.rsv_en = 0; bus_a.flush = 0;
    bus_s.w_en = 0; bus_s.rsv_en = 0; bus_s.flush = 0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef DYT_RF_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    rst = 1'b0;
    idle();
    bus_a.w_addr = '0; bus_a.w_data = '0; bus_a.r_a_addr = 5'd5; bus_a.r_b_addr = 5'd7; bus_a.rsv_addr = 5'd7;
    bus_s.w_addr = '0; bus_s.w_data = '0; bus_s.r_a_addr = '0; bus_s.r_b_addr = '0; bus_s.rsv_addr = '0;
    bus_a.rsv_en = 1;
    #12;
    chk("rst_a_data", bus_a.r_a_data, 0);
    chk("rst_b_busy", bus_a.r_b_busy, 0);
    chk("rst_stall", bus_a.rsv_stall, 0);
    chk("rst_cnt", bus_a.busy_cnt, 0);
    bus_a.rsv_en = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: write x5, write x0 ignored
    bus_a.w_en = 1; bus_a.w_addr = 5; bus_a.w_data = 32'hDEADBEEF;
    tick();
    idle(); bus_a.r_a_addr = 5; #1;
    chk("t1_x5_data", bus_a.r_a_data, 32'hDEADBEEF);
    chk("t1_x5_busy", bus_a.r_a_busy, 0);
    bus_a.w_en = 1; bus_a.w_addr = 0; bus_a.w_data = 32'h1234;
    tick();
    idle(); bus_a.r_a_addr = 0; #1;
    chk("t1_x0_data", bus_a.r_a_data, 0);

    // 2: reserve x7, then reserve again stalls
    bus_a.rsv_en = 1; bus_a.rsv_addr = 7; #1;
    chk("t2_first_stall", bus_a.rsv_stall, 0);
    tick();
    idle(); bus_a.r_b_addr = 7; #1;
    chk("t2_x7_busy", bus_a.r_b_busy, 1);
    chk("t2_cnt1", bus_a.busy_cnt, 1);
    bus_a.rsv_en = 1; #1;
    chk("t2_restall", bus_a.rsv_stall, 1);
    tick();
    idle(); #1;
    chk("t2_cnt_hold", bus_a.busy_cnt, 1);

    // 3: same-cycle write+reserve on x7
    bus_a.w_en = 1; bus_a.w_addr = 7; bus_a.w_data = 32'hA5A5A5A5;
    bus_a.rsv_en = 1; bus_a.rsv_addr = 7; #1;
    chk("t3_stall", bus_a.rsv_stall, 0);
    chk("t3_b_data_now", bus_a.r_b_data, byp ? 32'hA5A5A5A5 : 32'h0);
    chk("t3_b_busy_now", bus_a.r_b_busy, byp ? 0 : 1);
    tick();
    idle(); #1;
    chk("t3_data", bus_a.r_b_data, 32'hA5A5A5A5);
    chk("t3_busy", bus_a.r_b_busy, 1);
    chk("t3_cnt", bus_a.busy_cnt, 1);

    // 4: reserve x1..x3, then flush with reserve x4 and write x5
    for (int i = 1; i <= 3; i++) begin
      bus_a.rsv_en = 1; bus_a.rsv_addr = 5'(i);
      tick();
    end
    idle(); #1;
    chk("t4_cnt4", bus_a.busy_cnt, 4);
    bus_a.flush = 1; bus_a.rsv_en = 1; bus_a.rsv_addr = 4;
    bus_a.w_en = 1; bus_a.w_addr = 5; bus_a.w_data = 32'h77;
    tick();
    idle(); bus_a.r_a_addr = 4; bus_a.r_b_addr = 1; #1;
    chk("t4_x4_busy", bus_a.r_a_busy, 0);
    chk("t4_x1_busy", bus_a.r_b_busy, 0);
    chk("t4_cnt0", bus_a.busy_cnt, 0);
    bus_a.r_a_addr = 5; #1;
    chk("t4_flush_wr", bus_a.r_a_data, 32'h77);
    tick();
    chk("t4_cnt0_late", bus_a.busy_cnt, 0);

    // reserve x0 has no effect and never stalls
    bus_a.rsv_en = 1; bus_a.rsv_addr = 0;
    tick();
    #1;
    chk("x0_rsv_stall", bus_a.rsv_stall, 0);
    idle(); bus_a.r_a_addr = 0; #1;
    chk("x0_busy", bus_a.r_a_busy, 0);
    chk("x0_cnt", bus_a.busy_cnt, 0);

    // 5: 16-reg instance, fill x1..x15
    for (int i = 1; i <= 15; i++) begin
      bus_s.rsv_en = 1; bus_s.rsv_addr = 4'(i);
      tick();
    end
    bus_s.rsv_addr = 0;
    tick();
    idle(); #1;
    chk("t5_cnt15", bus_s.busy_cnt, 15);
    bus_s.rsv_en = 1; bus_s.rsv_addr = 15; #1;
    chk("t5_full_stall", bus_s.rsv_stall, 1);
    bus_s.rsv_en = 0;
    bus_s.w_en = 1; bus_s.w_addr = 15; bus_s.w_data = 32'hF00D;
    tick();
    idle(); bus_s.r_a_addr = 15; #1;
    chk("t5_cnt14", bus_s.busy_cnt, 14);
    chk("t5_x15_data", bus_s.r_a_data, 32'hF00D);
    chk("t5_x15_busy", bus_s.r_a_busy, 0);

    // 6: same-cycle read of written register
    bus_a.w_en = 1; bus_a.w_addr = 9; bus_a.w_data = 32'h11;
    bus_a.rsv_en = 1; bus_a.rsv_addr = 9;
    tick();
    idle();
    bus_a.w_en = 1; bus_a.w_addr = 9; bus_a.w_data = 32'h55; bus_a.r_a_addr = 9; #1;
    chk("t6_same_data", bus_a.r_a_data, byp ? 32'h55 : 32'h11);
    chk("t6_same_busy", bus_a.r_a_busy, byp ? 0 : 1);
    tick();
    idle(); #1;
    chk("t6_next_data", bus_a.r_a_data, 32'h55);
    chk("t6_next_busy", bus_a.r_a_busy, 0);

    // reset mid-operation
    bus_a.rsv_en = 1; bus_a.rsv_addr = 10;
    tick();
    bus_a.r_b_addr = 10; #1;
    chk("t6_pre_rst_busy", bus_a.r_b_busy, 1);
    #2;
    rst = 1'b0; #1;
    chk("t6_rst_a_data", bus_a.r_a_data, 0);
    chk("t6_rst_b_busy", bus_a.r_b_busy, 0);
    chk("t6_rst_stall", bus_a.rsv_stall, 0);
    chk("t6_rst_cnt", bus_a.busy_cnt, 0);
    chk("t6_rst_s_cnt", bus_s.busy_cnt, 0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("t6_post_rst_data", bus_a.r_a_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
